qclk_load_ctrl: RTL

QCLK_LOAD_CTRL -- requirements
Module: qclk_load_ctrl

---
 rtl/qclk_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/qclk_load_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/qclk_pkg.sv
// ---------------------------------------------------------------------------
// qclk_pkg
// Shared definitions for the qclk load controller and its arbiter.
//   qclk_state_t       : controller FSM state encoding
//   QCLK_WIDTH_DEFAULT : default qclk counter width
//   HOLDOFF_W          : width of the holdoff down-counter (holds 0..15)
// ---------------------------------------------------------------------------
package qclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } qclk_state_t;

  localparam int QCLK_WIDTH_DEFAULT = 32;
  localparam int HOLDOFF_W          = 4;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts at index
// ptr and wraps from N_REQ-1 back to 0; the first asserted request wins.
// Ports:
//   req       : in  [N_REQ-1:0]  request vector
//   ptr       : in  [IDX_W-1:0]  index where the search begins
//   grant     : out [N_REQ-1:0]  one-hot winner (all zero if no request)
//   grant_idx : out [IDX_W-1:0]  binary index of the winner
//   any       : out              at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Walk the requesters starting at ptr; candidate indices are reduced
  // modulo N_REQ by a single subtraction since ptr < N_REQ always holds.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qclk_load_ctrl.sv
// ---------------------------------------------------------------------------
// qclk_load_ctrl
// Arbitrates several requesters that want to load a new value into the
// qclk counter. A winner is picked round-robin from IDLE, acknowledged on
// the same edge, and its value (+1 to cover the capture cycle) is strobed
// to the counter one cycle later. HOLDOFF idle cycles follow every load.
// Ports:
//   clk         : in   sole clock, rising edge
//   rst         : in   asynchronous reset, active low
//   req         : in   [N_REQ-1:0]        level requests, held until ack
//   req_val     : in   [N_REQ*WIDTH-1:0]  slice i is requester i's value
//   ack         : out  [N_REQ-1:0]        one-cycle consume pulse
//   load_enable : out  one-cycle load strobe
//   in_val      : out  [WIDTH-1:0]        load value, zero when no strobe
//   busy        : out  controller is occupied with a load/holdoff
//   load_cnt    : out  [15:0] saturating load counter, present only when
//                 QCLK_LOAD_CTRL_LOAD_CNT_EN is defined
// ---------------------------------------------------------------------------
module qclk_load_ctrl
  import qclk_pkg::*;
#(
  parameter int WIDTH   = QCLK_WIDTH_DEFAULT,
  parameter int N_REQ   = 4,
  parameter int HOLDOFF = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_val,
  output logic [N_REQ-1:0]       ack,
  output logic                   load_enable,
  output logic [WIDTH-1:0]       in_val,
`ifdef QCLK_LOAD_CTRL_LOAD_CNT_EN
  output logic [15:0]            load_cnt,
`endif
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [HOLDOFF_W-1:0] HOLD_LAST = HOLDOFF_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  qclk_state_t          state, next_state;
  logic [IDX_W-1:0]     rr_ptr, ptr_d;
  logic [HOLDOFF_W-1:0] hold_cnt, hold_cnt_d;
  logic [WIDTH-1:0]     latched_val, latch_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 load_en_q, load_en_d;
  logic [WIDTH-1:0]     in_val_q, in_val_d;
  logic                 busy_q, busy_d;
  logic [N_REQ-1:0]     win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  // State register; reset drops straight back to IDLE, aborting any load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state logic. GRANT skips HOLDOFF entirely when no holdoff is set.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (win_any) next_state = ST_GRANT;
      ST_GRANT:   next_state = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
      ST_HOLDOFF: if (hold_cnt == '0) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output and datapath next values. All outputs are registered, so ack
  // appears with the GRANT state and the load strobe one cycle later.
  // busy covers the whole occupied window up to the cycle the controller
  // is able to accept the next request.
  always_comb begin
    ack_d      = '0;
    load_en_d  = 1'b0;
    in_val_d   = '0;
    busy_d     = (state != ST_IDLE) || (next_state != ST_IDLE);
    hold_cnt_d = hold_cnt;
    ptr_d      = rr_ptr;
    latch_d    = latched_val;
    case (state)
      ST_IDLE: begin
        if (win_any) begin
          ack_d   = win_onehot;
          latch_d = req_val[win_idx*WIDTH +: WIDTH];
          ptr_d   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_GRANT: begin
        load_en_d  = 1'b1;
        in_val_d   = latched_val + 1'b1;
        hold_cnt_d = HOLD_LAST;
      end
      ST_HOLDOFF: begin
        if (hold_cnt != '0) hold_cnt_d = hold_cnt - 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state, all cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q       <= '0;
      load_en_q   <= 1'b0;
      in_val_q    <= '0;
      busy_q      <= 1'b0;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
      latched_val <= '0;
    end else begin
      ack_q       <= ack_d;
      load_en_q   <= load_en_d;
      in_val_q    <= in_val_d;
      busy_q      <= busy_d;
      hold_cnt    <= hold_cnt_d;
      rr_ptr      <= ptr_d;
      latched_val <= latch_d;
    end
  end

  assign ack         = ack_q;
  assign load_enable = load_en_q;
  assign in_val      = in_val_q;
  assign busy        = busy_q;

`ifdef QCLK_LOAD_CTRL_LOAD_CNT_EN
  // Counts load strobes, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   load_cnt <= '0;
    else if (load_en_q && (load_cnt != 16'hFFFF)) load_cnt <= load_cnt + 16'd1;
  end
`endif

endmodule
